// File: rtl/fft_n_rad2_pkg.sv
// fft_n_rad2_pkg: complex sample and twiddle types, twiddle fixed-point format
// and a bit-reversal helper shared by the fft_n_rad2 block and its butterfly.
package fft_n_rad2_pkg;

   // Twiddles are Q2.14: 16384 represents 1.0.
   localparam int TW_FRAC_BITS = 14;

   typedef struct packed {
      logic signed [31:0] r;
      logic signed [31:0] i;
   } complex_product_t;

   typedef struct packed {
      logic signed [15:0] r;
      logic signed [15:0] i;
   } complex_fixed_t;

   // Reverse the low nbits of idx (used at elaboration time to wire stage 0).
   function automatic int bit_rev(input int idx, input int nbits);
      int res;
      res = 32'sd0;
      for (int k = 0; k < nbits; k++) begin
         res[k] = idx[nbits-1-k];
      end
      return res;
   endfunction

endpackage

// File: rtl/fft_butterfly_rad2.sv
// fft_butterfly_rad2: combinational radix-2 DIT butterfly.
//   P = W*B (48-bit products, >>> 14, low 32 bits kept), X = A + P, Y = A - P.
// Sums wrap in two's complement. With FFT_STAGE_SCALE_EN defined, X and Y are
// arithmetic-shifted right by one so a full FFT comes out divided by N.
module fft_butterfly_rad2
   import fft_n_rad2_pkg::*;
(
   input  complex_product_t a_i,
   input  complex_product_t b_i,
   input  complex_fixed_t   w_i,
   output complex_product_t x_o,
   output complex_product_t y_o
);

   logic signed [47:0] prod_r_s;
   logic signed [47:0] prod_i_s;
   logic signed [47:0] shr_r_s;
   logic signed [47:0] shr_i_s;
   logic signed [31:0] p_r_s;
   logic signed [31:0] p_i_s;
   logic signed [31:0] sum_r_s;
   logic signed [31:0] sum_i_s;
   logic signed [31:0] dif_r_s;
   logic signed [31:0] dif_i_s;

   // Twiddle multiply, rescale out of Q2.14, then wrap-around add and subtract.
   always_comb begin
      prod_r_s = 48'(w_i.r) * 48'(b_i.r) - 48'(w_i.i) * 48'(b_i.i);
      prod_i_s = 48'(w_i.r) * 48'(b_i.i) + 48'(w_i.i) * 48'(b_i.r);
      shr_r_s  = prod_r_s >>> TW_FRAC_BITS;
      shr_i_s  = prod_i_s >>> TW_FRAC_BITS;
      p_r_s    = shr_r_s[31:0];
      p_i_s    = shr_i_s[31:0];
      sum_r_s  = a_i.r + p_r_s;
      sum_i_s  = a_i.i + p_i_s;
      dif_r_s  = a_i.r - p_r_s;
      dif_i_s  = a_i.i - p_i_s;
`ifdef FFT_STAGE_SCALE_EN
      x_o.r = sum_r_s >>> 1;
      x_o.i = sum_i_s >>> 1;
      y_o.r = dif_r_s >>> 1;
      y_o.i = dif_i_s >>> 1;
`else
      x_o.r = sum_r_s;
      x_o.i = sum_i_s;
      y_o.r = dif_r_s;
      y_o.i = dif_i_s;
`endif
   end

endmodule

// File: rtl/fft_n_rad2.sv
// fft_n_rad2: streaming-input, parallel-output radix-2 DIT FFT of size N.
// Samples are collected into an N-entry frame (enable gates capture), the frame
// is loaded bit-reversed into stage 0, then flows through NUM_STAGES registered
// butterfly stages. fft_out holds the last stage register (natural-order bins)
// and out_valid pulses for one cycle per frame, NUM_STAGES edges after capture.
// Optional macro FFT_STAGE_SCALE_EN halves every butterfly output (DFT / N).
module fft_n_rad2
   import fft_n_rad2_pkg::*;
#(
   parameter int N               = 128,
   parameter int NUM_STAGES      = $clog2(N),
   parameter int NUM_BUTTERFLIES = N / 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  complex_product_t         data_in,
   input  logic signed [15:0]       W_R_STAGE [NUM_STAGES][NUM_BUTTERFLIES],
   input  logic signed [15:0]       W_I_STAGE [NUM_STAGES][NUM_BUTTERFLIES],
   output complex_product_t [N-1:0] fft_out,
   output logic                     out_valid
);

   localparam logic [NUM_STAGES-1:0] CNT_LAST = NUM_STAGES'(N - 1);

   logic [NUM_STAGES-1:0] cnt_q;
   logic [NUM_STAGES-1:0] cnt_d;
   logic                  frame_done_s;
   complex_product_t      buf_q   [N-1];
   complex_product_t      load_d  [N];
   complex_product_t      bf_d    [NUM_STAGES][N];
   complex_product_t      stage_q [NUM_STAGES+1][N];
   logic [NUM_STAGES:0]   valid_q;

   // Sample counter next state; the frame completes on the N-th enabled sample.
   always_comb begin
      frame_done_s = 1'b0;
      cnt_d        = cnt_q;
      if (enable) begin
         frame_done_s = (cnt_q == CNT_LAST);
         cnt_d        = frame_done_s ? '0 : cnt_q + 1'b1;
      end else begin
         cnt_d        = cnt_q;
      end
   end

   // Stage-0 load pattern: element j takes frame sample bitrev(j); the last
   // sample comes straight from data_in on the completing edge.
   for (genvar j = 0; j < N; j++) begin : g_load
      localparam int SRC = bit_rev(j, NUM_STAGES);
      if (SRC == N - 1) begin : g_live
         assign load_d[j] = data_in;
      end else begin : g_buf
         assign load_d[j] = buf_q[SRC];
      end
   end

   // Butterfly array: stage s pairs elements h = 2^s apart within 2h-wide groups.
   for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
      for (genvar b = 0; b < NUM_BUTTERFLIES; b++) begin : g_bf
         localparam int H   = 1 << s;
         localparam int TOP = (b / H) * 2 * H + (b % H);
         localparam int BOT = TOP + H;
         complex_fixed_t w_s;
         assign w_s = '{r: W_R_STAGE[s][b], i: W_I_STAGE[s][b]};
         fft_butterfly_rad2 u_bf (
            .a_i (stage_q[s][TOP]),
            .b_i (stage_q[s][BOT]),
            .w_i (w_s),
            .x_o (bf_d[s][TOP]),
            .y_o (bf_d[s][BOT])
         );
      end
   end

   // Capture, frame load and pipeline advance; a stage reloads only when the
   // stage feeding it holds a frame, so the last stage holds between results.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '0;
         valid_q <= '0;
         for (int j = 0; j < N - 1; j++) begin
            buf_q[j] <= '0;
         end
         for (int s = 0; s <= NUM_STAGES; s++) begin
            for (int j = 0; j < N; j++) begin
               stage_q[s][j] <= '0;
            end
         end
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= {valid_q[NUM_STAGES-1:0], frame_done_s};
         if (enable && (cnt_q != CNT_LAST)) begin
            buf_q[cnt_q] <= data_in;
         end
         if (frame_done_s) begin
            for (int j = 0; j < N; j++) begin
               stage_q[0][j] <= load_d[j];
            end
         end
         for (int s = 0; s < NUM_STAGES; s++) begin
            if (valid_q[s]) begin
               for (int j = 0; j < N; j++) begin
                  stage_q[s+1][j] <= bf_d[s][j];
               end
            end
         end
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_out
      assign fft_out[k] = stage_q[NUM_STAGES][k];
   end
   assign out_valid = valid_q[NUM_STAGES];

endmodule

// File: tb/tb_fft_n_rad2.sv
// tb_fft_n_rad2: N = 8 bench. Known-answer table (impulse, DC, alternating),
// random frames against a sub-DFT reference model, pulse spacing with a gap,
// mid-frame reset and in-flight discard. FFT_STAGE_SCALE_EN scales expectations.
module tb_fft_n_rad2;
   import fft_n_rad2_pkg::*;

   localparam int N = 8;
   localparam int S = $clog2(N);
   localparam int B = N / 2;

   typedef struct { int r[N]; int i[N]; } frame_t;
   typedef struct { string name; frame_t x; frame_t e; int gap_at; int gap_len; } vec_t;

   logic                     clk = 1'b0;
   logic                     reset = 1'b0;
   logic                     enable = 1'b0;
   complex_product_t         data_in;
   logic signed [15:0]       w_r [S][B];
   logic signed [15:0]       w_i [S][B];
   complex_product_t [N-1:0] fft_out;
   logic                     out_valid;

   int     tw_r [B];
   int     tw_i [B];
   int     n_checks = 0;
   int     n_fail = 0;
   int     cyc = 0;
   frame_t exp_q [$];
   int     cap_q [$];
   int     pulse_q [$];
   vec_t   tbl [3];

   fft_n_rad2 #(.N(N)) dut (
      .clk(clk), .reset(reset), .enable(enable), .data_in(data_in),
      .W_R_STAGE(w_r), .W_I_STAGE(w_i), .fft_out(fft_out), .out_valid(out_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic frame_t zero_frame();
      frame_t f;
      for (int k = 0; k < N; k++) begin f.r[k] = 0; f.i[k] = 0; end
      return f;
   endfunction

   // Reference: build DFTs of size 2m from pairs of size-m DFTs over
   // stride-decimated subsequences, using the fixed-point twiddle rules.
   function automatic frame_t model(input frame_t x);
      int cr[N], ci[N], nr[N], ni[N];
      int m2, nsub, e, ar, ai, br, bi, pr32, pi32, s0, s1, d0, d1;
      longint pr, pi;
      frame_t y;
      for (int j = 0; j < N; j++) begin cr[j] = x.r[j]; ci[j] = x.i[j]; end
      for (int m = 1; m < N; m = m * 2) begin
         m2 = 2 * m;
         nsub = N / m2;
         for (int r = 0; r < nsub; r++) begin
            for (int k = 0; k < m; k++) begin
               e  = k * (N / m2);
               ar = cr[r*m+k];        ai = ci[r*m+k];
               br = cr[(r+nsub)*m+k]; bi = ci[(r+nsub)*m+k];
               pr = (longint'(tw_r[e]) * br - longint'(tw_i[e]) * bi) >>> 14;
               pi = (longint'(tw_r[e]) * bi + longint'(tw_i[e]) * br) >>> 14;
               pr32 = int'(pr); pi32 = int'(pi);
               s0 = ar + pr32; s1 = ai + pi32; d0 = ar - pr32; d1 = ai - pi32;
`ifdef FFT_STAGE_SCALE_EN
               s0 = s0 >>> 1; s1 = s1 >>> 1; d0 = d0 >>> 1; d1 = d1 >>> 1;
`endif
               nr[r*m2+k] = s0;   ni[r*m2+k] = s1;
               nr[r*m2+k+m] = d0; ni[r*m2+k+m] = d1;
            end
         end
         for (int j = 0; j < N; j++) begin cr[j] = nr[j]; ci[j] = ni[j]; end
      end
      for (int j = 0; j < N; j++) begin y.r[j] = cr[j]; y.i[j] = ci[j]; end
      return y;
   endfunction

   function automatic frame_t rand_frame();
      frame_t f;
      for (int k = 0; k < N; k++) begin
         f.r[k] = int'($urandom_range(40000, 0)) - 20000;
         f.i[k] = int'($urandom_range(40000, 0)) - 20000;
      end
      return f;
   endfunction

   // Drive nsamp samples of x (enable low for gap_len cycles before sample gap_at).
   task automatic run_frame(input frame_t x, input int nsamp, input int gap_at,
                            input int gap_len, input bit expect_it, input frame_t e);
      for (int n = 0; n < nsamp; n++) begin
         if (n == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               @(negedge clk);
               enable = 1'b0;
               data_in.r = 32'sd12345; data_in.i = -32'sd777;
            end
         end
         @(negedge clk);
         enable = 1'b1;
         data_in.r = x.r[n];
         data_in.i = x.i[n];
         if (n == N - 1 && expect_it) begin
            exp_q.push_back(e);
            cap_q.push_back(cyc + 1);
         end
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      @(negedge clk);
      enable = 1'b0;
      while (exp_q.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
      chk("drain_pending_frames", exp_q.size(), 0);
      exp_q.delete();
      cap_q.delete();
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_valid"}, out_valid, 0);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("%s_bin%0d_r", nm, k), fft_out[k].r, 0);
         chk($sformatf("%s_bin%0d_i", nm, k), fft_out[k].i, 0);
      end
   endtask

   // Output monitor: every pulse must match the oldest outstanding frame.
   always @(negedge clk) begin
      if (reset && out_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: got out_valid=1 at cycle %0d, expected 0", cyc);
         end else begin
            frame_t e;
            int c;
            e = exp_q.pop_front();
            c = cap_q.pop_front();
            chk("latency", cyc - c, S);
            for (int k = 0; k < N; k++) begin
               chk($sformatf("bin%0d_r", k), fft_out[k].r, e.r[k]);
               chk($sformatf("bin%0d_i", k), fft_out[k].i, e.i[k]);
            end
            pulse_q.push_back(cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_t f, g;
      real v;
      data_in = '0;
      for (int e = 0; e < B; e++) begin
         v = 16384.0 * $cos(2.0 * 3.14159265358979 * e / N);
         tw_r[e] = int'(v);
         v = -16384.0 * $sin(2.0 * 3.14159265358979 * e / N);
         tw_i[e] = int'(v);
      end
      for (int s = 0; s < S; s++) begin
         for (int b = 0; b < B; b++) begin
            w_r[s][b] = 16'(tw_r[(b % (1 << s)) * (N / (2 << s))]);
            w_i[s][b] = 16'(tw_i[(b % (1 << s)) * (N / (2 << s))]);
         end
      end

      // Known-answer table.
      tbl[0].name = "impulse"; tbl[0].x = zero_frame(); tbl[0].e = zero_frame();
      tbl[0].x.r[0] = 1000;
      for (int k = 0; k < N; k++) tbl[0].e.r[k] = 1000;
      tbl[1].name = "dc"; tbl[1].x = zero_frame(); tbl[1].e = zero_frame();
      for (int k = 0; k < N; k++) tbl[1].x.r[k] = 100;
      tbl[1].e.r[0] = 800;
      tbl[2].name = "alternating"; tbl[2].x = zero_frame(); tbl[2].e = zero_frame();
      for (int k = 0; k < N; k++) tbl[2].x.r[k] = (k % 2 == 0) ? 100 : -100;
      tbl[2].e.r[4] = 800;
      for (int v2 = 0; v2 < 3; v2++) begin
         tbl[v2].gap_at = -1; tbl[v2].gap_len = 0;
`ifdef FFT_STAGE_SCALE_EN
         for (int k = 0; k < N; k++) tbl[v2].e.r[k] = tbl[v2].e.r[k] >>> S;
`endif
      end
      tbl[2].gap_at = 4; tbl[2].gap_len = 3;

      // Reset state.
      #12;
      check_zero("reset");
      @(negedge clk);
      reset = 1'b1;

      // Table frames back to back; the last one has a 3-cycle enable gap.
      for (int v2 = 0; v2 < 3; v2++) begin
         run_frame(tbl[v2].x, N, tbl[v2].gap_at, tbl[v2].gap_len, 1'b1, tbl[v2].e);
      end
      drain();
      chk("pulse_count", pulse_q.size(), 3);
      if (pulse_q.size() >= 3) begin
         chk("pulse_spacing_back_to_back", pulse_q[1] - pulse_q[0], N);
         chk("pulse_spacing_with_gap", pulse_q[2] - pulse_q[1], N + 3);
      end
      repeat (4) @(negedge clk);
      chk("hold_bin4_r", fft_out[4].r, tbl[2].e.r[4]);
      chk("hold_valid_low", out_valid, 0);

      // Randomized frames against the reference model.
      for (int t = 0; t < 8; t++) begin
         f = rand_frame();
         run_frame(f, N, int'($urandom_range(N - 1, 0)), int'($urandom_range(2, 0)),
                   1'b1, model(f));
      end
      drain();

      // Reset after 5 samples of a partial frame: outputs clear at once.
      f = rand_frame();
      run_frame(f, N, -1, 0, 1'b1, model(f));
      g = rand_frame();
      run_frame(g, 5, -1, 0, 1'b0, g);
      @(negedge clk);
      enable = 1'b0;
      chk("prereset_bin0_nonzero", (fft_out[0].r != 0 || fft_out[0].i != 0) ? 1 : 0, 1);
      #2 reset = 1'b0;
      #1 check_zero("midframe_reset");
      @(negedge clk);
      reset = 1'b1;
      run_frame(tbl[0].x, N, -1, 0, 1'b1, tbl[0].e);
      drain();

      // Reset with a frame in flight: it must never appear.
      f = rand_frame();
      run_frame(f, N, -1, 0, 1'b0, f);
      @(negedge clk);
      enable = 1'b0;
      #2 reset = 1'b0;
      #1 check_zero("inflight_reset");
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      f = rand_frame();
      run_frame(f, N, -1, 0, 1'b1, model(f));
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_n_rad2.md
# fft_n_rad2

Streaming-input, parallel-output radix-2 decimation-in-time FFT of configurable size N. Complex samples arrive one per clock, and the block collects each group of N samples into a frame. Each frame passes through a registered log2(N)-stage butterfly pipeline, and all N natural-order bins are presented in parallel with a one-cycle valid pulse. The block sits between the sample source (OFDM symbol stream) and downstream per-bin processing. Twiddle factors are supplied externally per stage and per butterfly from a LUT.

## Interface
Parameters:
- N, 128, FFT size; power of two, at least 4.
- NUM_STAGES, $clog2(N), number of butterfly stages (derived).
- NUM_BUTTERFLIES, N/2, number of butterflies per stage (derived).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  when high, data_in is captured on this edge.
- data_in  in  complex_product_t  input sample; fields r and i are each signed 32-bit.
- W_R_STAGE  in  signed 16 [NUM_STAGES][NUM_BUTTERFLIES]  twiddle real parts, Q2.14 (16384 = 1.0).
- W_I_STAGE  in  signed 16 [NUM_STAGES][NUM_BUTTERFLIES]  twiddle imaginary parts, Q2.14.
- fft_out  out  complex_product_t [N-1:0]  bins in natural order; fft_out[k] is X[k].
- out_valid  out  1  one-cycle pulse when fft_out holds a new frame result.

## Operation
- Capture:
  - A sample counter cnt runs 0..N-1 and advances only when enable is high.
  - Samples go into an input buffer at index cnt.
  - When enable is high and cnt = N-1, the N-sample frame (buffered samples plus the current data_in) loads into the stage-0 register in bit-reversed index order, and v0 is set. Otherwise v0 is cleared.
  - cnt then wraps to 0.
- Stage s, for s = 0..NUM_STAGES-1, using butterfly b = 0..N/2-1:
  - h = 2^s.
  - top = (b/h)*2h + (b mod h).
  - bot = top + h.
  - P = W*B, where W = (W_R_STAGE[s][b], W_I_STAGE[s][b]) and B is the bot element.
  - P uses 48-bit intermediate products, is arithmetic-shifted right by 14, and is truncated to 32 bits.
  - The top element becomes A + P and the bot element becomes A - P.
  - Sums wrap (two's complement); there is no saturation.
- Twiddle contents are the caller's responsibility. The standard table is W = e^(-j2πe/N) with exponent e = (b mod h)*N/(2h).
- Each stage register carries a valid bit. The pipeline advances every cycle regardless of enable.
- fft_out is the last stage register. It holds its value until the next frame result. out_valid is the last stage's valid bit.

## Timing
- Reset forces cnt, all buffers, all stage registers, fft_out (all zero) and out_valid (0) to zero immediately, independent of clk.
- Reset asserted mid-frame discards the partial frame and any in-flight results; capture restarts at cnt = 0.
- Latency: out_valid rises NUM_STAGES rising edges after the edge that captured the frame's last sample. For N = 8 this is 3 edges; for N = 128 it is 7.
- out_valid lasts exactly one cycle per frame.
- Continuous enable gives back-to-back frames, with out_valid pulses every N cycles and no throughput loss.
- With enable low, capture pauses and cnt holds. The frame completes on the N-th enabled sample, and gaps are allowed.

## Configuration
- Macro FFT_STAGE_SCALE_EN.
- When defined, every butterfly output is arithmetic-shifted right by 1 before registering, so the overall output is the DFT divided by N.
- When undefined, there is no scaling and the output is the unscaled DFT.

## Structure
- Shared package (headers.svh) holds:
  - complex_product_t: struct of signed [31:0] r and i.
  - complex_fixed_t: struct of signed [15:0] r and i.
  - The twiddle fraction-bits constant (14).
- One sub-module, fft_butterfly_rad2: combinational inputs A, B and W, outputs X and Y, with the scaling macro applied inside it.
- The top level instantiates fft_butterfly_rad2 NUM_STAGES × NUM_BUTTERFLIES times via generate.

## Test plan
All scenarios use N = 8, the standard twiddle table and enable held high.
- Impulse: x[0] = (1000,0), rest 0 -> every fft_out[k] = (1000,0); out_valid pulses 3 edges after the 8th sample.
- DC: all samples = (100,0) -> fft_out[0] = (800,0), others (0,0).
- Alternating +100/-100 -> fft_out[4] = (800,0), others (0,0).
- Two back-to-back frames (impulse, then DC) -> out_valid pulses exactly 8 cycles apart with the respective results; enable low for 3 cycles mid-frame delays the pulse by 3 cycles.
- Reset:
  - Asserting reset after 5 samples -> out_valid = 0 and fft_out = 0 immediately.
  - The next full frame is computed correctly.
- With FFT_STAGE_SCALE_EN defined, impulse (1000,0) -> every bin = (125,0).
